// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
//   Bundles the request/response signals of the reset sequencer.
//
//   Parameters:
//     CHANNELS     number of sequenced reset outputs
//
//   Signals:
//     soft_req     synchronous re-sequence request (driven by the slave side)
//     rst_out      active-high per-subsystem resets (driven by the sequencer)
//     done         all reset outputs released (driven by the sequencer)
//     cause        last sequence cause, 01 = hard reset, 10 = soft request
//                  (only with RESET_SEQUENCER_CAUSE_EN)
//     restart_cnt  saturating count of accepted soft requests
//                  (only with RESET_SEQUENCER_CAUSE_EN)
//
//   Modports:
//     master       the sequencer itself
//     slave        the consumer of the resets / source of soft_req
//
//   Optional feature macro: RESET_SEQUENCER_CAUSE_EN
// -----------------------------------------------------------------------------
interface reset_sequencer_if #(
    parameter int CHANNELS = 3
);
    logic                soft_req;
    logic [CHANNELS-1:0] rst_out;
    logic                done;
`ifdef RESET_SEQUENCER_CAUSE_EN
    logic [1:0]          cause;
    logic [7:0]          restart_cnt;

    modport master (input soft_req, output rst_out, output done,
                    output cause, output restart_cnt);
    modport slave  (output soft_req, input rst_out, input done,
                    input cause, input restart_cnt);
`else
    modport master (input soft_req, output rst_out, output done);
    modport slave  (output soft_req, input rst_out, input done);
`endif
endinterface

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Synchronises an external asynchronous reset and releases CHANNELS reset
//   outputs one at a time in index order. All outputs are held for DELAY
//   cycles after the sequence start edge, then bit k is released at
//   start + DELAY + k*STAGE_GAP. A soft request restarts the whole sequence.
//
//   Parameters:
//     CHANNELS     number of reset outputs (>= 1)
//     DELAY        cycles from sequence start to release of rst_out[0] (>= 1)
//     STAGE_GAP    cycles between successive channel releases (>= 1)
//     SYNC_STAGES  flops in the reset-deassertion synchroniser (>= 2)
//
//   Ports:
//     clk          system clock
//     reset        asynchronous active-high reset, asserts all outputs at once
//     bus          reset_sequencer_if.master (soft_req in; rst_out, done out;
//                  cause, restart_cnt out when the optional feature is built)
//
//   Optional feature macro: RESET_SEQUENCER_CAUSE_EN
//     Adds cause (01 hard / 10 soft) and a saturating 8-bit restart counter.
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int CHANNELS    = 3,
    parameter int DELAY       = 4,
    parameter int STAGE_GAP   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    reset_sequencer_if.master  bus
);

    localparam int MAX_CNT = (DELAY > STAGE_GAP) ? DELAY : STAGE_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // The phase starts with the counter at 0 on the start edge itself, so the
    // release edge is the one where the counter already holds length-1.
    localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        STAGE = 2'd1,
        RUN   = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Reset synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   irst;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
    end

    // NOTE: the chain is set asynchronously so irst asserts the moment reset
    // rises, but it can only clear by shifting zeros through on clk, which
    // makes the release of irst synchronous to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign irst = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [IDX_W-1:0]    stage_q, stage_d;
    logic [CHANNELS-1:0] rst_out_q, rst_out_d;
    logic                done_q,  done_d;
`ifdef RESET_SEQUENCER_CAUSE_EN
    logic [1:0]          cause_q, cause_d;
    logic [7:0]          rcnt_q,  rcnt_d;
`endif

    // NOTE: every variable gets its hold value first so no path through the
    // case leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;
`ifdef RESET_SEQUENCER_CAUSE_EN
        cause_d   = cause_q;
        rcnt_d    = rcnt_q;
`endif

        if (bus.soft_req) begin
            // Restart wins over any release due on the same edge.
            state_d   = HOLD;
            cnt_d     = '0;
            stage_d   = '0;
            rst_out_d = '1;
            done_d    = 1'b0;
`ifdef RESET_SEQUENCER_CAUSE_EN
            cause_d   = 2'b10;
            if (rcnt_q != 8'hFF) begin
                rcnt_d = rcnt_q + 8'd1;
            end
`endif
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == DELAY_TC) begin
                        cnt_d        = '0;
                        rst_out_d[0] = 1'b0;
                        if (CHANNELS == 1) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = STAGE;
                            stage_d = IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                STAGE: begin
                    if (cnt_q == GAP_TC) begin
                        cnt_d              = '0;
                        rst_out_d[stage_q] = 1'b0;
                        if (stage_q == LAST_IDX) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            stage_d = stage_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                RUN: begin
                    // Outputs hold until a soft request or a reset.
                end

                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

    // irst is asserted asynchronously by reset, so it alone covers both the
    // external reset and the synchroniser hold-off; soft_req has no effect
    // while it is high because these flops are held in reset.
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // values, independent of statement order.
    always_ff @(posedge clk or posedge irst) begin
        if (irst) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            stage_q   <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
`ifdef RESET_SEQUENCER_CAUSE_EN
            cause_q   <= 2'b01;
            rcnt_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
`ifdef RESET_SEQUENCER_CAUSE_EN
            cause_q   <= cause_d;
            rcnt_q    <= rcnt_d;
`endif
        end
    end

    assign bus.rst_out = rst_out_q;
    assign bus.done    = done_q;
`ifdef RESET_SEQUENCER_CAUSE_EN
    assign bus.cause       = cause_q;
    assign bus.restart_cnt = rcnt_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//   Drives two sequencers from one reset / soft_req pair:
//     u_a : defaults (CHANNELS=3, DELAY=4, STAGE_GAP=2, SYNC_STAGES=2)
//     u_b : CHANNELS=1, DELAY=1, STAGE_GAP=5, SYNC_STAGES=3
//   The reference model tracks, per instance, how many edges have passed
//   since the sequence start edge; bit k is expected released once that age
//   reaches DELAY + k*STAGE_GAP.
//   Optional feature macro: RESET_SEQUENCER_CAUSE_EN
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic soft_req;

    int checks   = 0;
    int failures = 0;

    reset_sequencer_if #(.CHANNELS(3)) bus_a ();
    reset_sequencer_if #(.CHANNELS(1)) bus_b ();

    assign bus_a.soft_req = soft_req;
    assign bus_b.soft_req = soft_req;

    reset_sequencer #(
        .CHANNELS(3), .DELAY(4), .STAGE_GAP(2), .SYNC_STAGES(2)
    ) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.master)
    );

    reset_sequencer #(
        .CHANNELS(1), .DELAY(1), .STAGE_GAP(5), .SYNC_STAGES(3)
    ) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.master)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int age      [2];  // edges since sequence start, -1 while held in reset
    int sync_cnt [2];  // edges seen with reset low since the last reset
    int cause_m  [2];
    int rcnt_m   [2];

    function automatic int p_ch  (int i); return (i == 0) ? 3 : 1; endfunction
    function automatic int p_dly (int i); return (i == 0) ? 4 : 1; endfunction
    function automatic int p_gap (int i); return (i == 0) ? 2 : 5; endfunction
    function automatic int p_sync(int i); return (i == 0) ? 2 : 3; endfunction

    function automatic logic [31:0] exp_rst(int i);
        logic [31:0] v = '0;
        for (int k = 0; k < p_ch(i); k++) begin
            v[k] = (age[i] < 0) || (age[i] < p_dly(i) + k * p_gap(i));
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_done(int i);
        return {31'd0, (age[i] >= 0) &&
                       (age[i] >= p_dly(i) + (p_ch(i) - 1) * p_gap(i))};
    endfunction

    task automatic model_async_reset();
        for (int i = 0; i < 2; i++) begin
            age[i]      = -1;
            sync_cnt[i] = 0;
            cause_m[i]  = 1;
            rcnt_m[i]   = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                age[i]      = -1;
                sync_cnt[i] = 0;
            end else if (sync_cnt[i] < p_sync(i)) begin
                sync_cnt[i]++;
                age[i] = (sync_cnt[i] == p_sync(i)) ? 0 : -1;
            end else if (soft_req) begin
                age[i]     = 0;
                cause_m[i] = 2;
                if (rcnt_m[i] < 255) rcnt_m[i]++;
            end else if (age[i] < 1000000) begin
                age[i]++;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_a_rst"},  {29'd0, bus_a.rst_out}, exp_rst(0));
        check({tag, "_a_done"}, {31'd0, bus_a.done},    exp_done(0));
        check({tag, "_b_rst"},  {31'd0, bus_b.rst_out}, exp_rst(1));
        check({tag, "_b_done"}, {31'd0, bus_b.done},    exp_done(1));
`ifdef RESET_SEQUENCER_CAUSE_EN
        check({tag, "_a_cause"}, {30'd0, bus_a.cause},      32'(cause_m[0]));
        check({tag, "_a_rcnt"},  {24'd0, bus_a.restart_cnt}, 32'(rcnt_m[0]));
        check({tag, "_b_cause"}, {30'd0, bus_b.cause},      32'(cause_m[1]));
        check({tag, "_b_rcnt"},  {24'd0, bus_b.restart_cnt}, 32'(rcnt_m[1]));
`endif
    endtask

    // One clock cycle: drive on the falling edge, check 1 time unit after
    // the rising edge.
    task automatic cycle(input logic r, input logic s);
        @(negedge clk);
        reset    = r;
        soft_req = s;
        if (r) model_async_reset();
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
    endtask

    // Reset raised between edges (call right after cycle()), held across
    // the following edges by the caller.
    task automatic mid_reset();
        #2;
        reset = 1'b1;
        model_async_reset();
        #1;
        check_all("mid");
        check("mid_rst_111", {29'd0, bus_a.rst_out}, 32'h7);
    endtask

    // Reset pulse that never spans a clock edge.
    task automatic glitch_reset();
        #1;
        reset = 1'b1;
        model_async_reset();
        #1;
        check_all("glitch");
        #1;
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset    = 1'b1;
        soft_req = 1'b0;
        model_async_reset();
        #1;
        check_all("por");

        repeat (3) cycle(1'b1, 1'b0);

        // Power-on release timeline
        for (int e = 1; e <= 12; e++) begin
            cycle(1'b0, 1'b0);
            if (e == 5)  check("plan_e5",  {29'd0, bus_a.rst_out}, 32'h7);
            if (e == 6)  check("plan_e6",  {29'd0, bus_a.rst_out}, 32'h6);
            if (e == 8)  check("plan_e8",  {29'd0, bus_a.rst_out}, 32'h4);
            if (e == 10) check("plan_e10", {30'd0, bus_a.rst_out, bus_a.done}, 32'h1);
            if (e == 3)  check("b_e3", {30'd0, bus_b.rst_out, bus_b.done}, 32'h2);
            if (e == 4)  check("b_e4", {30'd0, bus_b.rst_out, bus_b.done}, 32'h1);
        end

        // Soft pulse in RUN
        cycle(1'b0, 1'b1);
        check("soft_run", {28'd0, bus_a.rst_out, bus_a.done}, 32'he);
        repeat (4) cycle(1'b0, 1'b0);
        check("soft_run_s4", {29'd0, bus_a.rst_out}, 32'h6);

        // Soft pulse during STAGE
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        check("soft_stage", {29'd0, bus_a.rst_out}, 32'h7);
        repeat (4) cycle(1'b0, 1'b0);
        check("soft_stage_s4", {29'd0, bus_a.rst_out}, 32'h6);
        repeat (2) cycle(1'b0, 1'b0);
        check("pre_mid", {29'd0, bus_a.rst_out}, 32'h4);

        // Reset mid-cycle while rst_out = 100
        mid_reset();
        repeat (2) cycle(1'b1, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            cycle(1'b0, 1'b0);
            if (e == 5) check("rerel_e5", {29'd0, bus_a.rst_out}, 32'h7);
            if (e == 6) check("rerel_e6", {29'd0, bus_a.rst_out}, 32'h6);
        end

        // Soft request landing on the final release edge
        cycle(1'b0, 1'b1);
        repeat (7) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        check("final_edge", {28'd0, bus_a.rst_out, bus_a.done}, 32'he);

        // Soft request held for several edges
        repeat (5) cycle(1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0);
        check("held_s3", {29'd0, bus_a.rst_out}, 32'h7);
        cycle(1'b0, 1'b0);
        check("held_s4", {29'd0, bus_a.rst_out}, 32'h6);

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            int roll;
            roll = int'($urandom_range(0, 299));
            if (roll == 0) begin
                glitch_reset();
            end else if (roll == 1) begin
                repeat (int'($urandom_range(1, 3))) cycle(1'b1, 1'b0);
            end else begin
                cycle(1'b0, ($urandom_range(0, 9) == 0));
            end
        end

        // Long run of spaced soft pulses; the first lands while irst is high
        cycle(1'b1, 1'b0);
        repeat (300) begin
            cycle(1'b0, 1'b1);
            repeat (19) cycle(1'b0, 1'b0);
        end
`ifdef RESET_SEQUENCER_CAUSE_EN
        check("sat_rcnt",  {24'd0, bus_a.restart_cnt}, 32'd255);
        check("sat_cause", {30'd0, bus_a.cause},       32'd2);
        cycle(1'b1, 1'b0);
        check("rst_rcnt",  {24'd0, bus_a.restart_cnt}, 32'd0);
        check("rst_cause", {30'd0, bus_a.cause},       32'd1);
`else
        cycle(1'b1, 1'b0);
`endif
        repeat (12) cycle(1'b0, 1'b0);
        check("end_done", {31'd0, bus_a.done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
